// File: rtl/sumador_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM state encodings and
// the slice-counter width helper.
package sumador_pkg;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULO = 2'd1,
    LISTO   = 2'd2
  } estado_t;

  // A single-slice operation still needs a 1-bit counter to stay a legal vector.
  function automatic int ancho_contador(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sumador_completo_n.sv
// Combinational ripple of BITS full adders; also exposes the carry into the
// slice MSB so the caller can derive signed overflow.
module sumador_completo_n #(
  parameter int BITS = 1
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  output logic [BITS-1:0] s,
  output logic            cout,
  output logic            cmsb
);

  logic [BITS:0] c;

  // NOTE: combinational logic uses blocking assignments so each carry feeds the
  // next bit within the same evaluation; every output gets a value on every
  // pass, so no latch is inferred.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < BITS; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[BITS];
  assign cmsb = c[BITS-1];

endmodule

// File: rtl/sumador_serial_param.sv
// Multi-cycle adder/subtractor: processes BITS_POR_CICLO bits per clock, LSB
// slice first, linked by a carry flip-flop. Start/busy/done handshake.
module sumador_serial_param
  import sumador_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_POR_CICLO = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Inicio,
  input  logic             Resta,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryEntrada,
  output logic [WIDTH-1:0] Suma,
  output logic             CarrieSalida,
  output logic             Desborde,
  output logic             Ocupado,
  output logic             Listo
);

  localparam int N  = WIDTH / BITS_POR_CICLO;
  localparam int CW = ancho_contador(N);

  if (WIDTH < 2) begin : g_bad_width
    $error("sumador_serial_param: WIDTH must be at least 2");
  end
  if (BITS_POR_CICLO < 1 || (WIDTH % BITS_POR_CICLO) != 0) begin : g_bad_bpc
    $error("sumador_serial_param: BITS_POR_CICLO must divide WIDTH exactly");
  end

  estado_t estado, estado_sig;

  logic [CW-1:0]             cuenta;
  logic [WIDTH-1:0]          a_reg, b_reg;
  logic                      resta_reg;
  logic                      carry;
  logic                      aceptar;
  logic                      ultimo;
  logic [BITS_POR_CICLO-1:0] s_slice;
  logic                      cout_slice;
  logic                      cmsb_slice;

  assign ultimo = (cuenta == CW'(N - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) estado <= REPOSO;
    else     estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    aceptar    = 1'b0;
    case (estado)
      REPOSO: begin
        if (Inicio) begin
          aceptar    = 1'b1;
          estado_sig = CALCULO;
        end
      end
      CALCULO: begin
        if (ultimo) estado_sig = LISTO;
      end
      LISTO: begin
        if (Inicio) begin
          aceptar    = 1'b1;
          estado_sig = CALCULO;
        end else begin
          estado_sig = REPOSO;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  assign Ocupado = (estado == CALCULO);
  assign Listo   = (estado == LISTO);

  // Subtraction inverts B at the slice input; the forced carry-in of 1 is
  // loaded into the carry flip-flop when the operation is accepted.
  sumador_completo_n #(
    .BITS (BITS_POR_CICLO)
  ) u_slice (
    .a    (a_reg[BITS_POR_CICLO-1:0]),
    .b    (b_reg[BITS_POR_CICLO-1:0] ^ {BITS_POR_CICLO{resta_reg}}),
    .cin  (carry),
    .s    (s_slice),
    .cout (cout_slice),
    .cmsb (cmsb_slice)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      resta_reg    <= 1'b0;
      carry        <= 1'b0;
      cuenta       <= '0;
      Suma         <= '0;
      CarrieSalida <= 1'b0;
      Desborde     <= 1'b0;
    end else if (aceptar) begin
      a_reg        <= A;
      b_reg        <= B;
      resta_reg    <= Resta;
      carry        <= Resta | CarryEntrada;
      cuenta       <= '0;
      Suma         <= '0;
      CarrieSalida <= 1'b0;
      Desborde     <= 1'b0;
    end else if (estado == CALCULO) begin
      Suma[int'(cuenta) * BITS_POR_CICLO +: BITS_POR_CICLO] <= s_slice;
      a_reg  <= a_reg >> BITS_POR_CICLO;
      b_reg  <= b_reg >> BITS_POR_CICLO;
      carry  <= cout_slice;
      cuenta <= cuenta + CW'(1);
      if (ultimo) begin
        CarrieSalida <= cout_slice;
        Desborde     <= cout_slice ^ cmsb_slice;
      end
    end
  end

endmodule

// File: tb/tb_sumador_serial_param.sv
// Self-checking bench: two instances (1 and 4 bits per cycle) driven with
// directed and random operations, compared against a plain-arithmetic model.
module tb_sumador_serial_param;

  localparam int W  = 8;
  localparam int N1 = 8;
  localparam int N4 = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         inicio1, inicio4;
  logic         Resta, CarryEntrada;
  logic [W-1:0] A, B;

  logic [W-1:0] suma1, suma4;
  logic         cout1, cout4, desb1, desb4, ocup1, ocup4, listo1, listo4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sumador_serial_param #(.WIDTH(W), .BITS_POR_CICLO(1)) dut1 (
    .clk(clk), .rst(rst), .Inicio(inicio1), .Resta(Resta), .A(A), .B(B),
    .CarryEntrada(CarryEntrada), .Suma(suma1), .CarrieSalida(cout1),
    .Desborde(desb1), .Ocupado(ocup1), .Listo(listo1)
  );

  sumador_serial_param #(.WIDTH(W), .BITS_POR_CICLO(4)) dut4 (
    .clk(clk), .rst(rst), .Inicio(inicio4), .Resta(Resta), .A(A), .B(B),
    .CarryEntrada(CarryEntrada), .Suma(suma4), .CarrieSalida(cout4),
    .Desborde(desb4), .Ocupado(ocup4), .Listo(listo4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word modular arithmetic; overflow from operand/result signs.
  function automatic void modelo(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic resta, input logic cin,
                                 output logic [W-1:0] s, output logic c, output logic d);
    logic [W-1:0] be;
    logic [W:0]   full;
    logic         ce;
    be   = resta ? ~b : b;
    ce   = resta ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, be} + (W+1)'(ce);
    s    = full[W-1:0];
    c    = full[W];
    d    = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic resta, input logic cin, input bit intruso);
    logic [W-1:0] es, s1, s4;
    logic         ec, ed, c1, c4, d1, d4;
    int           lat1, lat4, ocu1, ocu4, lis1, lis4;
    modelo(a, b, resta, cin, es, ec, ed);
    s1 = '0; s4 = '0; c1 = 0; c4 = 0; d1 = 0; d4 = 0;
    lat1 = -1; lat4 = -1; lis1 = 0; lis4 = 0;
    A = a; B = b; Resta = resta; CarryEntrada = cin;
    inicio1 = 1'b1; inicio4 = 1'b1;
    tick();
    inicio1 = 1'b0; inicio4 = 1'b0;
    check("suma_cleared_at_start", suma1, '0);
    // Scramble inputs after the accepting edge; the result must not change.
    A = W'($urandom); B = W'($urandom);
    Resta = 1'($urandom); CarryEntrada = 1'($urandom);
    ocu1 = int'(ocup1); ocu4 = int'(ocup4);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (intruso && cyc == 3) begin
        inicio1 = 1'b1;
        A = W'($urandom); B = W'($urandom);
      end
      tick();
      inicio1 = 1'b0;
      ocu1 += int'(ocup1);
      ocu4 += int'(ocup4);
      if (listo1) begin
        lis1++;
        if (lat1 < 0) begin lat1 = cyc; s1 = suma1; c1 = cout1; d1 = desb1; end
      end
      if (listo4) begin
        lis4++;
        if (lat4 < 0) begin lat4 = cyc; s4 = suma4; c4 = cout4; d4 = desb4; end
      end
    end
    check("lat1", lat1, N1);
    check("suma1", s1, es);
    check("cout1", c1, ec);
    check("desb1", d1, ed);
    check("ocupado1_cycles", ocu1, N1);
    check("listo1_pulses", lis1, 1);
    check("suma1_hold", suma1, es);
    check("lat4", lat4, N4);
    check("suma4", s4, es);
    check("cout4", c4, ec);
    check("desb4", d4, ed);
    check("ocupado4_cycles", ocu4, N4);
    check("listo4_pulses", lis4, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] es;
    logic         ec, ed, prevl;
    int           prev, nl;

    rst = 1'b1; inicio1 = 0; inicio4 = 0;
    A = '0; B = '0; Resta = 0; CarryEntrada = 0;
    tick(); tick();
    check("reset_outs1", {suma1, cout1, desb1, ocup1, listo1}, '0);
    check("reset_outs4", {suma4, cout4, desb4, ocup4, listo4}, '0);
    rst = 1'b0;
    tick();

    // Directed cases.
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
    run_op(8'h05, 8'h07, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    run_op(8'h3C, 8'hA5, 1'b0, 1'b1, 1'b1);

    // Random operations, some with an ignored mid-operation start.
    for (int i = 0; i < 16; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    // Inicio held high: back-to-back results every N+1 cycles.
    Resta = 1'b0;
    A = W'($urandom); B = W'($urandom); CarryEntrada = 1'($urandom);
    modelo(A, B, Resta, CarryEntrada, es, ec, ed);
    q.push_back(es);
    inicio1 = 1'b1;
    tick();
    prev = 0; nl = 0; prevl = 1'b0;
    for (int cyc = 1; cyc <= 3 * (N1 + 1); cyc++) begin
      tick();
      if (listo1) begin
        nl++;
        check("cont_listo_single", prevl, 1'b0);
        check("cont_interval", cyc - prev, (nl == 1) ? N1 : N1 + 1);
        prev = cyc;
        check("cont_suma", suma1, q.pop_front());
        A = W'($urandom); B = W'($urandom); CarryEntrada = 1'($urandom);
        modelo(A, B, Resta, CarryEntrada, es, ec, ed);
        q.push_back(es);
      end
      prevl = listo1;
    end
    check("cont_count", nl, 3);
    inicio1 = 1'b0;
    repeat (N1 + 3) tick();

    // Reset in the middle of an operation.
    A = 8'h5A; B = 8'h00; Resta = 1'b0; CarryEntrada = 1'b0;
    inicio1 = 1'b1; inicio4 = 1'b1;
    tick();
    inicio1 = 1'b0; inicio4 = 1'b0;
    repeat (4) tick();
    check("partial_suma", suma1, 8'h0A);
    check("partial_ocupado", ocup1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_outs1", {suma1, cout1, desb1, ocup1, listo1}, '0);
    check("abort_outs4", {suma4, cout4, desb4, ocup4, listo4}, '0);
    tick();
    check("abort_stays_idle", {ocup1, listo1}, 2'b00);
    run_op(8'hC3, 8'h4E, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
